sequence_detector_v2: RTL
=========================

# sequence_detector_v2

Clocked, parametrised successor to the 2-bit sequence detector. Accepts a qualified stream of SYM_W-bit symbols and compares a sliding window of the last SEQ_LEN symbols against a run-time loadable pattern. On each match it pulses `result` for one cycle and increments a saturating match counter. Overlapping or non-overlapping match mode is selectable, and the counter can be cleared synchronously. Sits between the symbol source (switch/decoder front end) and the display/count logic.

## Interface
- SYM_W, 2, symbol width in bits (≥1)
- SEQ_LEN, 4, pattern length in symbols (≥2)
- CNT_W, 6, match counter width (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- SymValid  in  1  `InputDetector` carries a new symbol this cycle
- InputDetector  in  SYM_W  symbol
- PatternLoad  in  1  capture `PatternIn` this cycle
- PatternIn  in  SYM_W*SEQ_LEN  pattern; bits [SYM_W-1:0] = first (oldest) symbol
- Overlap  in  1  1 = overlapping matches allowed; 0 = window flushed after a match
- Clear  in  1  synchronous clear of `Count`
- result  out  1  one-cycle match pulse (registered)
- Count  out  CNT_W  saturating match count
- Fill  out  $clog2(SEQ_LEN+1)  number of valid symbols in the window (0..SEQ_LEN)

## Operation
- Reset values: result=0, Count=0, Fill=0, pattern register=0, window=0, state IDLE.
- State machine (3 states):
  - IDLE: no pattern loaded; symbols ignored; Fill stays 0; result is never asserted. PatternLoad → FILL.
  - FILL: each SymValid shifts the symbol into the window and increments Fill. When Fill reaches SEQ_LEN → ARMED (comparison applies to the symbol that fills the window).
  - ARMED: each SymValid shifts the window. If the new window equals the pattern: result=1 next cycle and Count+1. If Overlap=0 on a match: Fill←0 → FILL. If Overlap=1: stay ARMED.
- Window ordering: the oldest symbol is in the low slice; the newest symbol enters the high slice; the oldest is discarded.
- PatternLoad in FILL/ARMED: the pattern is replaced, Fill←0, and the window is flushed → FILL. Count is not affected.
- Count saturates at 2^CNT_W−1; further matches still pulse `result`.
- Overlap is sampled per match event; changing it mid-stream is legal.
- SymValid=0: no state change; result=0.

## Timing
- Latency: symbol sampled at edge N → result high during cycle N+1, Count updated at edge N.
- result is high for exactly one cycle per matching symbol; back-to-back matches in overlap mode give consecutive pulses.
- Priority within one edge: rst > PatternLoad > Clear > SymValid.
  - PatternLoad with SymValid: the symbol is discarded and no match is evaluated.
  - Clear with a match: Count←0, but result still pulses.
- Asynchronous reset mid-stream: all registers return to reset values immediately; the pattern must be reloaded.

## Structure
- Package `sequence_detector_pkg`: state enum (IDLE, FILL, ARMED) and the default parameter constants.
- Sub-module `seq_window_shift`: SEQ_LEN×SYM_W shift register with enable and synchronous flush, exposing a flat window bus. The top level holds the FSM, Fill counter, comparator and saturating counter.

## Test plan
Parameters SYM_W=2, SEQ_LEN=3 unless noted; pattern is written oldest first.
- Reset/IDLE: no PatternLoad, stream 11,00,10 → result never 1, Count=0, Fill=0.
- Basic match: load pattern 11,00,10; stream 11,00,10,11,00,01,10,10,11,00,01,10 → exactly one result pulse, the cycle after the third symbol; Count=1.
- Overlap mode: load 10,10,10; Overlap=1; stream five 10s → 3 pulses, Count=3. Repeat with Overlap=0 → 1 pulse, Count=1, and Fill=2 at the end.
- Saturation/Clear: CNT_W=2; force 5 matches → Count=3 and 5 pulses. Assert Clear coincident with a 6th match → Count=0 and result pulses.
- Reload priority: while ARMED, assert PatternLoad together with a SymValid that would match → no pulse, Fill=0, state FILL, new pattern active.
- Async reset mid-stream: assert rst between clock edges with Fill=2 → outputs zero immediately, and the FSM is back in IDLE.

Source files
------------

// File: rtl/sequence_detector_pkg.sv
// -----------------------------------------------------------------------------
// sequence_detector_pkg
// Shared types and default parameter values for sequence_detector_v2.
//   det_state_e : detector FSM states (IDLE, FILL, ARMED)
//   DEF_*       : default parameter constants for the top level
// -----------------------------------------------------------------------------
package sequence_detector_pkg;

    localparam int DEF_SYM_W   = 2;
    localparam int DEF_SEQ_LEN = 4;
    localparam int DEF_CNT_W   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no pattern loaded, symbols ignored
        FILL  = 2'd1,   // window partially populated
        ARMED = 2'd2    // window full, every symbol is compared
    } det_state_e;

endpackage

// File: rtl/seq_window_shift.sv
// -----------------------------------------------------------------------------
// seq_window_shift
// SEQ_LEN x SYM_W symbol shift register. The oldest symbol lives in the low
// slice; a shift drops it and inserts the new symbol in the high slice.
//   clk, rst     : clock, asynchronous active-high reset
//   shift_en_i   : shift sym_i into the window
//   flush_i      : synchronous clear of the whole window (wins over shift)
//   sym_i        : incoming symbol
//   window_o     : flat window bus, [SYM_W-1:0] = oldest symbol
// -----------------------------------------------------------------------------
module seq_window_shift #(
    parameter int SYM_W   = 2,
    parameter int SEQ_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_en_i,
    input  logic                     flush_i,
    input  logic [SYM_W-1:0]         sym_i,
    output logic [SEQ_LEN*SYM_W-1:0] window_o
);

    localparam int WIN_W = SEQ_LEN * SYM_W;

    logic [WIN_W-1:0] window_q;
    logic [WIN_W-1:0] window_d;

    always_comb begin
        window_d = window_q;
        if (flush_i) begin
            window_d = '0;
        end else if (shift_en_i) begin
            window_d = {sym_i, window_q[WIN_W-1:SYM_W]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

    assign window_o = window_q;

endmodule

// File: rtl/sequence_detector_v2.sv
// -----------------------------------------------------------------------------
// sequence_detector_v2
// Compares a sliding window of the last SEQ_LEN symbols against a run-time
// loadable pattern; pulses result for one cycle per match and keeps a
// saturating match count.
//   clk, rst       : clock, asynchronous active-high reset
//   SymValid       : InputDetector carries a symbol this cycle
//   InputDetector  : symbol
//   PatternLoad    : capture PatternIn (flushes window, restarts filling)
//   PatternIn      : pattern, [SYM_W-1:0] = oldest symbol
//   Overlap        : 1 = keep window after a match, 0 = flush it
//   Clear          : synchronous clear of Count
//   result         : registered one-cycle match pulse
//   Count          : saturating match count
//   Fill           : number of valid symbols in the window
// -----------------------------------------------------------------------------
module sequence_detector_v2
    import sequence_detector_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         SymValid,
    input  logic [SYM_W-1:0]             InputDetector,
    input  logic                         PatternLoad,
    input  logic [SYM_W*SEQ_LEN-1:0]     PatternIn,
    input  logic                         Overlap,
    input  logic                         Clear,
    output logic                         result,
    output logic [CNT_W-1:0]             Count,
    output logic [$clog2(SEQ_LEN+1)-1:0] Fill
);

    localparam int WIN_W  = SEQ_LEN * SYM_W;
    localparam int FILL_W = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    det_state_e        state_q, state_d;
    logic [FILL_W-1:0] fill_q,  fill_d;
    logic [WIN_W-1:0]  pat_q,   pat_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              result_q, result_d;

    logic              shift_en;
    logic              flush;
    logic [WIN_W-1:0]  window;
    logic [WIN_W-1:0]  window_next;

    seq_window_shift #(
        .SYM_W   (SYM_W),
        .SEQ_LEN (SEQ_LEN)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (shift_en),
        .flush_i    (flush),
        .sym_i      (InputDetector),
        .window_o   (window)
    );

    // Window as it will look once the current symbol is shifted in; the match
    // is judged on this so the result pulse lands the cycle after the symbol.
    assign window_next = {InputDetector, window[WIN_W-1:SYM_W]};

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        count_d  = count_q;
        result_d = 1'b0;
        shift_en = 1'b0;
        flush    = 1'b0;

        // Clear ranks above a concurrent match, so the increment below is
        // suppressed while it is asserted.
        if (Clear) begin
            count_d = '0;
        end

        if (PatternLoad) begin
            // A concurrent symbol is dropped; no match is evaluated.
            pat_d   = PatternIn;
            flush   = 1'b1;
            fill_d  = '0;
            state_d = FILL;
        end else if (SymValid && state_q != IDLE) begin
            shift_en = 1'b1;
            if (state_q == FILL) begin
                fill_d = fill_q + FILL_W'(1);
            end
            // The symbol that completes the window is compared too.
            if (state_q == ARMED || fill_q == FILL_LAST) begin
                state_d = ARMED;
                fill_d  = FILL_FULL;
                if (window_next == pat_q) begin
                    result_d = 1'b1;
                    if (!Clear && count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (!Overlap) begin
                        flush   = 1'b1;
                        fill_d  = '0;
                        state_d = FILL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fill_q   <= '0;
            pat_q    <= '0;
            count_q  <= '0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            pat_q    <= pat_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign Count  = count_q;
    assign Fill   = fill_q;

endmodule
